timer_rd_seq: RTL and testbench
===============================

// Module: timer_rd_seq
//
// PURPOSE
//  Read sequencer placed between the CPU/software-register side and timer_core.
//  - On a software request or a hardware trigger it pulses TIMER_SAMPLE for one cycle.
//  - It then captures the 2*DATA_W TIMER_VALUE into a shadow register.
//  - It returns the value as two DATA_W words, low word first, over a valid/ready stream.
//  - Both words come from the same snapshot, so a 64-bit read is atomic on a 32-bit bus.
//
// PARAMETERS
//  DATA_W   32   word width of the response stream; the timer value is 2*DATA_W wide
//
// PORTS
//  clk_i           in   1         system clock
//  arst_i          in   1         asynchronous reset, active-high
//  cke_i           in   1         clock enable; 0 freezes all state, all outputs held
//  req_valid_i     in   1         software read request
//  req_ready_o     out  1         request accepted when req_valid_i & req_ready_o
//  trig_i          in   1         hardware timestamp trigger, single-cycle pulse
//  timer_sample_o  out  1         to timer_core TIMER_SAMPLE
//  timer_value_i   in   2*DATA_W  from timer_core TIMER_VALUE
//  rsp_valid_o     out  1         response word valid
//  rsp_ready_i     in   1         response word consumed when rsp_valid_o & rsp_ready_i
//  rsp_data_o      out  DATA_W    response word: low half, then high half
//  rsp_last_o      out  1         high on the high-half word
//  busy_o          out  1         state != IDLE
//  overrun_o       out  1         sticky: trig_i arrived while not IDLE
//  overrun_clr_i   in   1         clears overrun_o
//
// BEHAVIOUR
//  - Reset: state=IDLE; shadow=0; timer_sample_o, rsp_valid_o, rsp_last_o, overrun_o = 0.
//    rsp_data_o=0. busy_o=0. req_ready_o=1 once reset is released.
//  - Reset mid-operation: abandon the transaction immediately and drop any pending word.
//  - FSM states: IDLE -> SAMPLE -> CAPTURE -> LO -> HI -> IDLE. Advance only when cke_i=1.
//  - IDLE:
//    - req_ready_o=1 (combinational on state).
//    - (req_valid_i | trig_i) -> SAMPLE.
//    - req_valid_i and trig_i in the same cycle merge into one capture.
//  - SAMPLE: timer_sample_o=1 for exactly one cycle (registered); -> CAPTURE.
//  - CAPTURE: timer_core has updated TIMER_VALUE; shadow <= timer_value_i at the closing edge; -> LO.
//  - LO:
//    - rsp_valid_o=1, rsp_data_o=shadow[DATA_W-1:0], rsp_last_o=0.
//    - Hold all three until rsp_ready_i, then -> HI.
//  - HI:
//    - rsp_valid_o=1, rsp_data_o=shadow[2*DATA_W-1:DATA_W], rsp_last_o=1.
//    - Hold until rsp_ready_i, then -> IDLE.
//  - Latency: request accepted at edge N -> first rsp_valid_o at cycle N+3.
//    With rsp_ready_i tied high, back-to-back reads complete every 5 cycles.
//  - rsp_data_o is stable while rsp_valid_o=1 and !rsp_ready_i, including across cke_i=0.
//    The shadow never changes outside CAPTURE.
//  - trig_i outside IDLE: ignored for capture; overrun_o <= 1.
//    Set and overrun_clr_i in the same cycle: set wins.
//  - req_valid_i outside IDLE: not accepted (req_ready_o=0); the requester holds it.
//  - Response words carry no source tag; trig-initiated captures produce a word pair like requests.
//
// STRUCTURE
//  - Shared header timer_rd_seq_def.vh: state encodings (3-bit localparams IDLE..HI), RSP_WORDS=2.
//  - One natural sub-module: iob_reg (with enable) for the 2*DATA_W shadow.
//  - FSM and flags stay in this module.
//
// TESTING (pair with timer_core, TIMER_ENABLE=1 from one cycle after reset)
//  1. Reset while in LO -> rsp_valid_o=0, busy_o=0, req_ready_o=1 on the next cycle.
//  2. req at cycle R, rsp_ready_i=1
//     -> timer_sample_o high only at R+1; words at R+3 and R+4; rsp_last_o only at R+4.
//  3. Two reads 1000 cycles apart
//     -> assembled 64-bit values differ by exactly 1000; high word 0.
//  4. Force timer_value_i = 64'h0000_0001_FFFF_FFFF at CAPTURE, rsp_ready_i held low 10 cycles
//     -> word 0xFFFFFFFF stable for all 10 cycles, then word 0x00000001.
//  5. trig_i while in LO -> overrun_o=1, no extra sample pulse.
//     overrun_clr_i with simultaneous trig_i -> still 1; clr alone -> 0.
//  6. req_valid_i & trig_i same cycle -> exactly one SAMPLE pulse, one word pair.
//     cke_i=0 for 5 cycles in SAMPLE -> pulse held, no state advance.

Source files
------------

// File: rtl/timer_rd_seq_pkg.sv
// Shared types for the timer read sequencer: FSM state encoding and word count.
package timer_rd_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SAMPLE  = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_LO      = 3'd3,
        ST_HI      = 3'd4
    } state_t;

    localparam int RSP_WORDS = 2;

    // True in the states that present a response word.
    function automatic logic is_rsp_state(input state_t s);
        return (s == ST_LO) || (s == ST_HI);
    endfunction

endpackage

// File: rtl/timer_rd_seq_shadow_reg.sv
// Enabled register holding the timer snapshot; written only when en is high.
module timer_rd_seq_shadow_reg #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/timer_rd_seq.sv
// Read sequencer: samples timer_core, snapshots the full-width value and returns
// it as a low/high word pair so a wide read is atomic over a narrow stream.
module timer_rd_seq
    import timer_rd_seq_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                arst_i,
    input  logic                cke_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                trig_i,
    output logic                timer_sample_o,
    input  logic [2*DATA_W-1:0] timer_value_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_data_o,
    output logic                rsp_last_o,
    output logic                busy_o,
    output logic                overrun_o,
    input  logic                overrun_clr_i
);

    state_t              state_q;
    state_t              state_d;
    logic                sample_q;
    logic                overrun_q;
    logic                shadow_en;
    logic [2*DATA_W-1:0] shadow;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (req_valid_i || trig_i) state_d = ST_SAMPLE;
            ST_SAMPLE:  state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_LO;
            ST_LO:      if (rsp_ready_i) state_d = ST_HI;
            ST_HI:      if (rsp_ready_i) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Everything, including the sample strobe and the overrun flag, freezes with cke_i.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q   <= ST_IDLE;
            sample_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else if (cke_i) begin
            state_q  <= state_d;
            sample_q <= (state_d == ST_SAMPLE);
            if (trig_i && (state_q != ST_IDLE)) begin
                overrun_q <= 1'b1;
            end else if (overrun_clr_i) begin
                overrun_q <= 1'b0;
            end
        end
    end

    // timer_core updates TIMER_VALUE the cycle after the sample strobe.
    assign shadow_en = cke_i && (state_q == ST_CAPTURE);

    timer_rd_seq_shadow_reg #(
        .W (2*DATA_W)
    ) u_shadow (
        .clk (clk_i),
        .rst (arst_i),
        .en  (shadow_en),
        .d   (timer_value_i),
        .q   (shadow)
    );

    always_comb begin
        rsp_data_o = '0;
        if (state_q == ST_LO) begin
            rsp_data_o = shadow[DATA_W-1:0];
        end else if (state_q == ST_HI) begin
            rsp_data_o = shadow[2*DATA_W-1:DATA_W];
        end
    end

    assign req_ready_o    = (state_q == ST_IDLE);
    assign busy_o         = (state_q != ST_IDLE);
    assign rsp_valid_o    = is_rsp_state(state_q);
    assign rsp_last_o     = (state_q == ST_HI);
    assign timer_sample_o = sample_q;
    assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_timer_rd_seq.sv
// Self-checking bench for timer_rd_seq with a free-running behavioural timer.
module tb_timer_rd_seq;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          arst = 1'b1;
    logic          cke = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          trig = 1'b0;
    logic          timer_sample;
    logic [2*DW-1:0] timer_value;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic          rsp_last;
    logic          busy;
    logic          overrun;
    logic          overrun_clr = 1'b0;

    logic [63:0] tval;
    logic [63:0] ofs = '0;
    logic        tv_force = 1'b0;
    logic [63:0] force_val = '0;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    // Behavioural timer_core: counts every cycle from reset.
    always @(posedge clk or posedge arst) begin
        if (arst) tval <= '0;
        else      tval <= tval + 64'd1;
    end

    assign timer_value = tv_force ? force_val : (tval + ofs);

    timer_rd_seq #(.DATA_W(DW)) dut (
        .clk_i          (clk),
        .arst_i         (arst),
        .cke_i          (cke),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .trig_i         (trig),
        .timer_sample_o (timer_sample),
        .timer_value_i  (timer_value),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_data_o     (rsp_data),
        .rsp_last_o     (rsp_last),
        .busy_o         (busy),
        .overrun_o      (overrun),
        .overrun_clr_i  (overrun_clr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(); step();
        nvec++; if (timer_sample !== 1'b0) begin nerr++; $display("FAIL rst_sample: got %b want 0", timer_sample); end
        nvec++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL rst_valid: got %b want 0", rsp_valid); end
        nvec++; if (rsp_last !== 1'b0) begin nerr++; $display("FAIL rst_last: got %b want 0", rsp_last); end
        nvec++; if (rsp_data !== '0) begin nerr++; $display("FAIL rst_data: got %h want 0", rsp_data); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_busy: got %b want 0", busy); end
        nvec++; if (overrun !== 1'b0) begin nerr++; $display("FAIL rst_overrun: got %b want 0", overrun); end
        arst = 1'b0;
        step();
        nvec++; if (req_ready !== 1'b1) begin nerr++; $display("FAIL rst_ready: got %b want 1", req_ready); end
        // reset while presenting the low word
        rsp_ready = 1'b0; req_valid = 1'b1;
        step(); req_valid = 1'b0;
        step(); step();
        nvec++; if (rsp_valid !== 1'b1) begin nerr++; $display("FAIL midrst_pre_valid: got %b want 1", rsp_valid); end
        arst = 1'b1;
        #1;
        nvec++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL midrst_valid: got %b want 0", rsp_valid); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL midrst_busy: got %b want 0", busy); end
        step(); arst = 1'b0;
        step();
        nvec++; if (req_ready !== 1'b1) begin nerr++; $display("FAIL midrst_ready: got %b want 1", req_ready); end
        nvec++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL midrst_valid2: got %b want 0", rsp_valid); end
    endtask

    task automatic test_latency();
        logic [63:0] exp;
        rsp_ready = 1'b1; req_valid = 1'b1;
        exp = tval + ofs + 64'd2;
        step(); req_valid = 1'b0;                    // R+1
        nvec++; if (timer_sample !== 1'b1) begin nerr++; $display("FAIL lat_sample_r1: got %b want 1", timer_sample); end
        nvec++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL lat_valid_r1: got %b want 0", rsp_valid); end
        step();                                      // R+2
        nvec++; if (timer_sample !== 1'b0) begin nerr++; $display("FAIL lat_sample_r2: got %b want 0", timer_sample); end
        nvec++; if ({busy, rsp_valid} !== 2'b10) begin nerr++; $display("FAIL lat_r2: got busy/valid %b want 10", {busy, rsp_valid}); end
        step();                                      // R+3
        nvec++; if ({rsp_valid, rsp_last} !== 2'b10) begin nerr++; $display("FAIL lat_r3_vl: got %b want 10", {rsp_valid, rsp_last}); end
        nvec++; if (rsp_data !== exp[31:0]) begin nerr++; $display("FAIL lat_r3_data: got %h want %h", rsp_data, exp[31:0]); end
        step();                                      // R+4
        nvec++; if ({rsp_valid, rsp_last} !== 2'b11) begin nerr++; $display("FAIL lat_r4_vl: got %b want 11", {rsp_valid, rsp_last}); end
        nvec++; if (rsp_data !== exp[63:32]) begin nerr++; $display("FAIL lat_r4_data: got %h want %h", rsp_data, exp[63:32]); end
        step();                                      // R+5
        nvec++; if ({rsp_valid, busy, timer_sample, req_ready} !== 4'b0001) begin nerr++; $display("FAIL lat_r5: got %b want 0001", {rsp_valid, busy, timer_sample, req_ready}); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_delta();
        logic [63:0] exp1, v1, v2;
        rsp_ready = 1'b1;
        req_valid = 1'b1; exp1 = tval + ofs + 64'd2;
        step(); req_valid = 1'b0;
        step(); step();
        v1[31:0] = rsp_data; step();
        v1[63:32] = rsp_data;
        for (int i = 0; i < 996; i++) step();        // next request 1000 cycles after the first
        req_valid = 1'b1;
        step(); req_valid = 1'b0;
        step(); step();
        v2[31:0] = rsp_data; step();
        v2[63:32] = rsp_data; step();
        nvec++; if (v1 !== exp1) begin nerr++; $display("FAIL delta_v1: got %h want %h", v1, exp1); end
        nvec++; if (v2 - v1 !== 64'd1000) begin nerr++; $display("FAIL delta_diff: got %0d want 1000", v2 - v1); end
        nvec++; if (v2[63:32] !== 32'd0) begin nerr++; $display("FAIL delta_hi: got %h want 0", v2[63:32]); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_hold();
        tv_force = 1'b1; force_val = 64'h0000_0001_FFFF_FFFF;
        rsp_ready = 1'b0; req_valid = 1'b1;
        step(); req_valid = 1'b0;
        step(); step();
        for (int i = 0; i < 10; i++) begin
            nvec++; if ({rsp_valid, rsp_last} !== 2'b10 || rsp_data !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL hold_lo[%0d]: got v/l %b data %h want 10 ffffffff", i, {rsp_valid, rsp_last}, rsp_data); end
            cke = !(i >= 4 && i <= 6);
            force_val = {$urandom, $urandom};        // shadow must ignore the input now
            step();
        end
        cke = 1'b1;
        nvec++; if (rsp_data !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL hold_lo_end: got %h want ffffffff", rsp_data); end
        rsp_ready = 1'b1;
        step();
        nvec++; if ({rsp_valid, rsp_last} !== 2'b11 || rsp_data !== 32'h1) begin nerr++; $display("FAIL hold_hi: got v/l %b data %h want 11 00000001", {rsp_valid, rsp_last}, rsp_data); end
        step();
        nvec++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL hold_done: got %b want 0", rsp_valid); end
        rsp_ready = 1'b0; tv_force = 1'b0;
    endtask

    task automatic test_overrun();
        rsp_ready = 1'b0; req_valid = 1'b1;
        step(); req_valid = 1'b0;
        step(); step();
        nvec++; if (overrun !== 1'b0) begin nerr++; $display("FAIL ovr_init: got %b want 0", overrun); end
        trig = 1'b1; step(); trig = 1'b0;
        nvec++; if (overrun !== 1'b1) begin nerr++; $display("FAIL ovr_set: got %b want 1", overrun); end
        nvec++; if ({timer_sample, rsp_valid, rsp_last} !== 3'b010) begin nerr++; $display("FAIL ovr_state: got s/v/l %b want 010", {timer_sample, rsp_valid, rsp_last}); end
        trig = 1'b1; overrun_clr = 1'b1; step(); trig = 1'b0;
        nvec++; if (overrun !== 1'b1) begin nerr++; $display("FAIL ovr_setwins: got %b want 1", overrun); end
        step(); overrun_clr = 1'b0;
        nvec++; if (overrun !== 1'b0) begin nerr++; $display("FAIL ovr_clr: got %b want 0", overrun); end
        rsp_ready = 1'b1;
        step();
        nvec++; if (timer_sample !== 1'b0) begin nerr++; $display("FAIL ovr_nosample_hi: got %b want 0", timer_sample); end
        step();
        nvec++; if ({timer_sample, busy} !== 2'b00) begin nerr++; $display("FAIL ovr_idle: got s/b %b want 00", {timer_sample, busy}); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_merge_cke();
        int pulses, words;
        logic [63:0] exp;
        rsp_ready = 1'b1; req_valid = 1'b1; trig = 1'b1;
        step(); req_valid = 1'b0; trig = 1'b0;
        pulses = 0; words = 0;
        for (int i = 0; i < 8; i++) begin
            pulses += int'(timer_sample);
            if (rsp_valid && rsp_ready) words++;
            step();
        end
        nvec++; if (pulses !== 1) begin nerr++; $display("FAIL merge_pulses: got %0d want 1", pulses); end
        nvec++; if (words !== 2) begin nerr++; $display("FAIL merge_words: got %0d want 2", words); end
        nvec++; if (overrun !== 1'b0) begin nerr++; $display("FAIL merge_overrun: got %b want 0", overrun); end
        trig = 1'b1; step(); trig = 1'b0;
        nvec++; if (timer_sample !== 1'b1) begin nerr++; $display("FAIL cke_sample0: got %b want 1", timer_sample); end
        cke = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            nvec++; if ({timer_sample, busy, rsp_valid} !== 3'b110) begin nerr++; $display("FAIL cke_frozen[%0d]: got s/b/v %b want 110", i, {timer_sample, busy, rsp_valid}); end
        end
        cke = 1'b1; exp = tval + ofs + 64'd1;
        step();
        nvec++; if ({timer_sample, rsp_valid} !== 2'b00) begin nerr++; $display("FAIL cke_capture: got s/v %b want 00", {timer_sample, rsp_valid}); end
        step();
        nvec++; if (rsp_valid !== 1'b1 || rsp_data !== exp[31:0]) begin nerr++; $display("FAIL cke_lo: got v %b data %h want 1 %h", rsp_valid, rsp_data, exp[31:0]); end
        step();
        nvec++; if (rsp_last !== 1'b1 || rsp_data !== exp[63:32]) begin nerr++; $display("FAIL cke_hi: got l %b data %h want 1 %h", rsp_last, rsp_data, exp[63:32]); end
        step();
        rsp_ready = 1'b0;
    endtask

    // Random request/trigger mix with random back-pressure, against a
    // transaction-level model: snapshot = timer two cycles after issue,
    // low word then high word from the third cycle on.
    task automatic test_random();
        logic [63:0] exp;
        int elapsed, words, kind;
        logic expv;
        for (int t = 0; t < 40; t++) begin
            ofs = ($urandom_range(0, 1) != 0) ? {$urandom, $urandom} : {$urandom, 32'hFFFF_FFF0};
            for (int g = $urandom_range(0, 2); g > 0; g--) step();
            nvec++; if (req_ready !== 1'b1 || busy !== 1'b0) begin nerr++; $display("FAIL rnd_idle[%0d]: got r/b %b want 10", t, {req_ready, busy}); end
            kind = $urandom_range(0, 2);
            req_valid = (kind != 1); trig = (kind != 0);
            exp = tval + ofs + 64'd2;
            step(); req_valid = 1'b0; trig = 1'b0;
            elapsed = 1; words = 0;
            while (words < 2 && elapsed < 40) begin
                expv = (elapsed >= 3);
                nvec++; if (timer_sample !== (elapsed == 1)) begin nerr++; $display("FAIL rnd_sample[%0d] c%0d: got %b", t, elapsed, timer_sample); end
                nvec++; if (rsp_valid !== expv) begin nerr++; $display("FAIL rnd_valid[%0d] c%0d: got %b want %b", t, elapsed, rsp_valid, expv); end
                rsp_ready = $urandom_range(0, 1);
                if (expv) begin
                    nvec++; if (rsp_data !== (words == 0 ? exp[31:0] : exp[63:32]) || rsp_last !== (words == 1)) begin
                        nerr++; $display("FAIL rnd_word[%0d].%0d: got %h last %b want %h", t, words, rsp_data, rsp_last, (words == 0 ? exp[31:0] : exp[63:32]));
                    end
                    if (rsp_ready) words++;
                end
                step();
                elapsed++;
            end
            rsp_ready = 1'b0;
            nvec++; if (words !== 2) begin nerr++; $display("FAIL rnd_timeout[%0d]: got %0d words want 2", t, words); end
        end
        ofs = '0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_delta();
        test_hold();
        test_overrun();
        test_merge_cke();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
